// File: rtl/pool2d_stream_kxk.sv
// pool2d_stream_kxk: streaming KxK "same"-padded 2D pooling engine.
//
// One raster-order pixel is taken per accepted cycle. A linear shift buffer
// holds the last (Kernel-1)*(IMG_Width+1) pixels. Together with the incoming
// pixel it covers every cell of the KxK window centred P rows and P columns
// behind the newest pixel. After the last pixel of a frame the block
// self-flushes P*W+P zero pixels so the bottom/right border windows complete.
//
// Ports:
//   CLK         clock, all logic on the rising edge
//   CLR         synchronous active-high reset / frame abort
//   In          signed input pixel (Datawidth bits)
//   Valid_IN    pixel valid; accepted when Valid_IN & In_Ready
//   Mode        0 = average, 1 = max; latched on first pixel of a frame
//   In_Ready    low only while the block flushes the frame tail
//   Out         pooled result (signed)
//   Valid_OUT   one-cycle qualifier per output
//   Frame_Done  pulse coincident with the last Valid_OUT of a frame
//   Dbg_State   current FSM state (IDLE=0, RUN=1, FLUSH=2)
//
// Handshake: a pixel transfers on a rising edge where Valid_IN and In_Ready
// are both high. The output side has no backpressure; Valid_OUT qualifies Out
// for exactly one cycle, two cycles after the feed that completes the window.
//
// Optional build macro POOL_RELU_EN: negative results are clamped to 0
// before the Out register, in both modes. Latency is unchanged.
module pool2d_stream_kxk #(
  parameter int IMG_Width  = 8,
  parameter int IMG_Height = 8,
  parameter int Datawidth  = 16,
  parameter int Kernel     = 3,
  parameter int Stride     = 1
) (
  input  logic                        CLK,
  input  logic                        CLR,
  input  logic signed [Datawidth-1:0] In,
  input  logic                        Valid_IN,
  input  logic                        Mode,
  output logic                        In_Ready,
  output logic signed [Datawidth-1:0] Out,
  output logic                        Valid_OUT,
  output logic                        Frame_Done,
  output logic [1:0]                  Dbg_State
);
  localparam int P      = (Kernel - 1) / 2;
  localparam int KK     = Kernel * Kernel;
  localparam int CTR    = P * Kernel + P;
  localparam int SRL    = (Kernel - 1) * (IMG_Width + 1);
  localparam int NPIX   = IMG_Width * IMG_Height;
  localparam int NLEAD  = P * IMG_Width + P;
  localparam int NTOT   = NPIX + NLEAD;
  localparam int NW     = $clog2(NTOT);
  localparam int RW     = $clog2(IMG_Height);
  localparam int CW     = $clog2(IMG_Width);
  localparam int SW     = Datawidth + $clog2(KK);
  localparam int LAST_R = ((IMG_Height - 1) / Stride) * Stride;
  localparam int LAST_C = ((IMG_Width - 1) / Stride) * Stride;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [NW-1:0]               n_q, n_d;      // feed index within the frame
  logic [RW-1:0]               cr_q, cr_d;    // centre row of the next window
  logic [CW-1:0]               cc_q, cc_d;    // centre column of the next window
  logic                        mode_q, mode_d;
  logic                        feed, complete;
  logic signed [Datawidth-1:0] feed_px;

  logic signed [Datawidth-1:0] sr_q [SRL];
  logic signed [Datawidth-1:0] tap [SRL+1];
  logic signed [Datawidth-1:0] win_d [KK];
  logic signed [Datawidth-1:0] win_q [KK];
  logic [KK-1:0]               msk_d, msk_q;
  logic                        v1_d, v1_q, last1_d, last1_q, mode1_q;

  logic signed [SW-1:0]        sum;
  logic signed [SW:0]          quo;
  logic signed [Datawidth-1:0] mx, res;

  assign Dbg_State = state_q;

  // FSM next state and feed control
  always_comb begin
    state_d  = state_q;
    In_Ready = (state_q != ST_FLUSH);
    // In FLUSH a zero pixel is fed every cycle and Valid_IN is ignored.
    feed     = (state_q == ST_FLUSH) || Valid_IN;
    feed_px  = (state_q == ST_FLUSH) ? '0 : In;
    unique case (state_q)
      ST_IDLE:  if (Valid_IN) state_d = ST_RUN;
      ST_RUN:   if (Valid_IN && n_q == NW'(NPIX - 1)) state_d = ST_FLUSH;
      ST_FLUSH: if (n_q == NW'(NTOT - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters; the first P*W+P feeds only prime the buffer.
  always_comb begin
    n_d      = n_q;
    cr_d     = cr_q;
    cc_d     = cc_q;
    mode_d   = mode_q;
    complete = feed && (n_q >= NW'(NLEAD));
    if (state_q == ST_IDLE && Valid_IN) mode_d = Mode;
    if (feed) n_d = (n_q == NW'(NTOT - 1)) ? '0 : n_q + 1'b1;
    if (complete) begin
      if (cc_q == CW'(IMG_Width - 1)) begin
        cc_d = '0;
        cr_d = (cr_q == RW'(IMG_Height - 1)) ? '0 : cr_q + 1'b1;
      end else begin
        cc_d = cc_q + 1'b1;
      end
    end
    v1_d    = complete && (int'(cr_q) % Stride == 0) && (int'(cc_q) % Stride == 0);
    last1_d = (cr_q == RW'(LAST_R)) && (cc_q == CW'(LAST_C));
  end

  // Window gather: cell (i,j) is offset (Kernel-1-i)*W + (Kernel-1-j) behind
  // the newest pixel. The column test also masks buffer wrap across rows.
  always_comb begin
    msk_d  = '0;
    tap[0] = feed_px;
    for (int k = 1; k <= SRL; k++) tap[k] = sr_q[k-1];
    for (int i = 0; i < Kernel; i++) begin
      for (int j = 0; j < Kernel; j++) begin
        msk_d[i*Kernel+j] = (int'(cr_q) + i - P >= 0) && (int'(cr_q) + i - P < IMG_Height) &&
                            (int'(cc_q) + j - P >= 0) && (int'(cc_q) + j - P < IMG_Width);
        win_d[i*Kernel+j] = msk_d[i*Kernel+j] ? tap[(Kernel-1-i)*IMG_Width + (Kernel-1-j)] : '0;
      end
    end
  end

  // Reduce: pad-inclusive average (padding already zeroed) or in-image max.
  always_comb begin
    sum = '0;
    for (int k = 0; k < KK; k++) sum = sum + SW'(win_q[k]);
    // Signed division truncates toward zero.
    quo = (SW+1)'(sum) / (SW+1)'(KK);
    mx  = win_q[CTR];
    for (int k = 0; k < KK; k++) begin
      if (msk_q[k] && win_q[k] > mx) mx = win_q[k];
    end
    res = mode1_q ? mx : quo[Datawidth-1:0];
`ifdef POOL_RELU_EN
    if (res < 0) res = '0;
`else
    res = res;
`endif
  end

  // Control and output registers
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      cr_q       <= '0;
      cc_q       <= '0;
      mode_q     <= 1'b0;
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      mode1_q    <= 1'b0;
      Out        <= '0;
      Valid_OUT  <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cr_q       <= cr_d;
      cc_q       <= cc_d;
      mode_q     <= mode_d;
      v1_q       <= v1_d;
      last1_q    <= last1_d;
      mode1_q    <= mode_q;
      if (v1_q) Out <= res;
      Valid_OUT  <= v1_q;
      Frame_Done <= v1_q && last1_q;
    end
  end

  // Line buffer and window register; contents need no reset (masked).
  always_ff @(posedge CLK) begin
    if (feed) begin
      sr_q[0] <= feed_px;
      for (int k = 1; k < SRL; k++) sr_q[k] <= sr_q[k-1];
    end
    if (complete) begin
      for (int k = 0; k < KK; k++) win_q[k] <= win_d[k];
      msk_q <= msk_d;
    end
  end
endmodule

// File: tb/tb_pool2d_stream_kxk.sv
module tb_pool2d_stream_kxk;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus / DUT wiring ----------------
  logic signed [DW-1:0] px = '0;
  logic vin  = 1'b0;
  logic mode = 1'b0;
  int   sel  = 0;

  logic [2:0]           vin_u;
  logic                 rdy_u [3];
  logic                 vo_u  [3];
  logic                 fd_u  [3];
  logic signed [DW-1:0] o_u   [3];
  logic [1:0]           st_u  [3];
  logic                 rdy, vo, fd;
  logic signed [DW-1:0] o;
  logic [1:0]           st;

  assign vin_u[0] = vin && (sel == 0);
  assign vin_u[1] = vin && (sel == 1);
  assign vin_u[2] = vin && (sel == 2);
  assign rdy = rdy_u[sel];
  assign vo  = vo_u[sel];
  assign fd  = fd_u[sel];
  assign o   = o_u[sel];
  assign st  = st_u[sel];

  pool2d_stream_kxk #(.IMG_Width(4), .IMG_Height(4), .Datawidth(DW), .Kernel(3), .Stride(1)) u_w4k3 (
    .CLK(clk), .CLR(clr), .In(px), .Valid_IN(vin_u[0]), .Mode(mode), .In_Ready(rdy_u[0]),
    .Out(o_u[0]), .Valid_OUT(vo_u[0]), .Frame_Done(fd_u[0]), .Dbg_State(st_u[0]));
  pool2d_stream_kxk #(.IMG_Width(8), .IMG_Height(8), .Datawidth(DW), .Kernel(3), .Stride(2)) u_w8s2 (
    .CLK(clk), .CLR(clr), .In(px), .Valid_IN(vin_u[1]), .Mode(mode), .In_Ready(rdy_u[1]),
    .Out(o_u[1]), .Valid_OUT(vo_u[1]), .Frame_Done(fd_u[1]), .Dbg_State(st_u[1]));
  pool2d_stream_kxk #(.IMG_Width(7), .IMG_Height(7), .Datawidth(DW), .Kernel(7), .Stride(1)) u_w7k7 (
    .CLK(clk), .CLR(clr), .In(px), .Valid_IN(vin_u[2]), .Mode(mode), .In_Ready(rdy_u[2]),
    .Out(o_u[2]), .Valid_OUT(vo_u[2]), .Frame_Done(fd_u[2]), .Dbg_State(st_u[2]));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Hand-computed expected frames (raster order)
  int t_avg9   [16] = '{4, 6, 6, 4, 6, 9, 9, 6, 6, 9, 9, 6, 4, 6, 6, 4};
  int t_max4   [16] = '{5, 6, 7, 7, 9, 10, 11, 11, 13, 14, 15, 15, 13, 14, 15, 15};
  int t_avgneg [16] = '{-1, -2, -2, -2, -3, -5, -6, -4, -5, -9, -10, -7, -4, -7, -8, -5};
  int t_max8   [16] = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};
  int t_nr7    [7]  = '{4, 5, 6, 7, 6, 5, 4};

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q [$];   // {frame_done, value}
  int          expn_q [$];  // completing feed index of each expected output
  int          acc_cyc [$]; // cycle in which each pixel of the frame was offered and taken
  bit          chk_lat = 1'b0;
  logic [DW:0] mon_e;
  int          mon_n;

  task automatic push_exp(input int v, input bit f, input int n);
    logic [DW:0] e;
    e = {f, DW'(v)};
    exp_q.push_back(e);
    expn_q.push_back(n);
  endtask

  // Flush feeds follow the last accepted pixel on consecutive cycles.
  function automatic int feed_cyc(input int n);
    if (acc_cyc.size() == 0) return -1;
    if (n < acc_cyc.size()) return acc_cyc[n];
    return acc_cyc[acc_cyc.size()-1] + (n - acc_cyc.size() + 1);
  endfunction

  always @(negedge clk) begin
    if (vin && rdy) acc_cyc.push_back(cyc);
    if (vo) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_valid_out", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = expn_q.pop_front();
        check_eq("out_value", o, $signed(mon_e[DW-1:0]));
        check_eq("frame_done", fd, mon_e[DW]);
        if (chk_lat) check_eq("latency", cyc, feed_cyc(mon_n) + 2);
      end
    end else if (fd) begin
      check_eq("stray_frame_done", 1, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_px(input logic signed [DW-1:0] v);
    int t;
    t = 0;
    while (!rdy && t < 100) begin @(posedge clk); #1; t++; end
    if (!rdy) check_eq("in_ready_timeout", rdy, 1);
    px  = v;
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  // kind: 0 = all 9, 1 = ramp, 2 = negative ramp, 3 = all -49
  task automatic send_frame(input int npx, input int kind, input bit gap, input bit flip);
    for (int i = 0; i < npx; i++) begin
      int val;
      case (kind)
        0:       val = 9;
        1:       val = i;
        2:       val = -i;
        default: val = -49;
      endcase
      send_px(DW'(val));
      if (flip && i == 0) mode = ~mode;
      if (gap && i != npx - 1) begin @(posedge clk); #1; end
    end
  endtask

  // Counts cycles with In_Ready low after the last pixel; optionally keeps
  // Valid_IN high during that time, dropping it before the block is ready.
  task automatic count_flush(input bit hold, output int lo);
    lo  = 0;
    px  = 16'sh1234;
    vin = hold;
    while (!rdy && lo < 200) begin lo++; @(posedge clk); #1; end
    vin = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(posedge clk); t++; end
    check_eq("outputs_pending", exp_q.size(), 0);
    exp_q.delete();
    expn_q.delete();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic push_4x4(input int kind_tab);
    for (int i = 0; i < 16; i++) begin
      int v;
      case (kind_tab)
        0:       v = t_avg9[i];
        1:       v = t_max4[i];
        default: v = t_avgneg[i];
      endcase
      push_exp(relu(v), i == 15, (i / 4 + 1) * 4 + i % 4 + 1);
    end
  endtask

  // ---------------- test sequence ----------------
  int lo;

  initial begin
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      check_eq("reset_in_ready", rdy, 1);
      check_eq("reset_valid_out", vo, 0);
      check_eq("reset_frame_done", fd, 0);
      check_eq("reset_out", o, 0);
      check_eq("reset_state_idle", st, 0);
    end
    sel = 0;
    clr = 1'b0;
    @(posedge clk); #1;

    // 4x4 K3 average, all 9
    mode = 1'b0; chk_lat = 1'b1; acc_cyc.delete();
    push_4x4(0);
    send_frame(16, 0, 1'b0, 1'b0);
    count_flush(1'b0, lo);
    check_eq("flush_len_4x4", lo, 5);
    wait_drain();

    // 4x4 K3 max ramp with Mode toggled after the first pixel, followed
    // back-to-back by an all-9 average frame (no CLR in between)
    mode = 1'b1; chk_lat = 1'b0;
    push_4x4(1);
    push_4x4(0);
    send_frame(16, 1, 1'b0, 1'b1);
    mode = 1'b0;
    send_frame(16, 0, 1'b0, 1'b0);
    wait_drain();

    // 8x8 K3 stride 2 max ramp
    sel = 1; mode = 1'b1; chk_lat = 1'b1; acc_cyc.delete();
    for (int i = 0; i < 16; i++)
      push_exp(relu(t_max8[i]), i == 15, (2 * (i / 4) + 1) * 8 + 2 * (i % 4) + 1);
    send_frame(64, 1, 1'b0, 1'b0);
    count_flush(1'b0, lo);
    check_eq("flush_len_8x8", lo, 9);
    wait_drain();

    // 7x7 K7 average, all -49
    sel = 2; mode = 1'b0; acc_cyc.delete();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        push_exp(relu(-(t_nr7[r] * t_nr7[c])), (r == 6) && (c == 6), (r + 3) * 7 + c + 3);
    send_frame(49, 3, 1'b0, 1'b0);
    count_flush(1'b0, lo);
    check_eq("flush_len_7x7", lo, 24);
    wait_drain();

    // 4x4 average negative ramp, Valid_IN toggling, Valid_IN held in FLUSH
    sel = 0; mode = 1'b0; acc_cyc.delete();
    push_4x4(2);
    send_frame(16, 2, 1'b1, 1'b0);
    count_flush(1'b1, lo);
    check_eq("flush_len_gapped", lo, 5);
    wait_drain();

    // CLR after 10 pixels: only windows fed before the abort edge emerge
    acc_cyc.delete();
    for (int i = 0; i < 4; i++) push_exp(relu(t_avg9[i]), 1'b0, 5 + i);
    send_frame(10, 0, 1'b0, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check_eq("ready_after_clr", rdy, 1);
    wait_drain();
    acc_cyc.delete();
    push_4x4(0);
    send_frame(16, 0, 1'b0, 1'b0);
    count_flush(1'b0, lo);
    check_eq("flush_len_after_clr", lo, 5);
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
